init_req_sched: RTL and testbench

- Round-robin scheduler that shares the single ray-initialisation unit (`init`) among N_REQ ray-generation requesters.
- Allocates a ray ID (RID) to each accepted request from a free list, then emits the init request stream {payload, rid} to `init`.
- Takes RID releases from the traversal back-end when a ray retires.
- Caps in-flight rays at 2**RID_WIDTH.

---
 rtl/init_req_sched.sv | 146 ++++++++++++++
 tb/tb_init_req_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/init_req_sched.sv
// Round-robin scheduler sharing one ray-init unit among N_REQ requesters; allocates RIDs from a free list.
// Latency 1 cycle request->output beat, 1 beat/cycle sustained; stalls (req_rdy=0) while beat held or no free RID.
// Optional INIT_REQ_SCHED_DOUBLE_FREE_CHECK_EN: outstanding-RID bitmap drops releases of unallocated RIDs.
module init_req_sched #(
    parameter int N_REQ         = 4,
    parameter int RID_WIDTH     = 8,
    parameter int PAYLOAD_WIDTH = 352
) (
    input  logic                               clk,
    input  logic                               arst,
    input  logic [N_REQ*PAYLOAD_WIDTH-1:0]     req_dat,
    input  logic [N_REQ-1:0]                   req_vld,
    output logic [N_REQ-1:0]                   req_rdy,
    output logic [PAYLOAD_WIDTH+RID_WIDTH-1:0] init_req_stream_rsc_dat,
    output logic                               init_req_stream_rsc_vld,
    input  logic                               init_req_stream_rsc_rdy,
    output logic [$clog2(N_REQ)-1:0]           init_req_src,
    input  logic                               rid_free_vld,
    input  logic [RID_WIDTH-1:0]               rid_free_dat,
    output logic [RID_WIDTH:0]                 inflight,
    output logic                               err
);
    localparam int DEPTH = 1 << RID_WIDTH;
    localparam int SRC_W = $clog2(N_REQ);
    localparam logic [RID_WIDTH:0] FULL_CNT = (RID_WIDTH+1)'(DEPTH);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]             state;
    logic                   run;
    logic [RID_WIDTH-1:0]   fill_cnt;
    logic [RID_WIDTH-1:0]   head;
    logic [RID_WIDTH-1:0]   tail;
    logic [RID_WIDTH:0]     free_cnt;
    logic [RID_WIDTH-1:0]   free_list [DEPTH];
    logic [SRC_W-1:0]       rr_ptr;
    logic [SRC_W-1:0]       grant_idx;
    logic                   grant_fnd;
    logic [PAYLOAD_WIDTH-1:0] grant_pay;
    logic                   load;
    logic                   rid_known;
    logic                   rel_ok;
    logic                   err_set;

    assign run = (state == ST_RUN);

    // rr_ptr holds the first index to search, i.e. last grant + 1
    always_comb begin
        int cand;
        grant_idx = '0;
        grant_fnd = 1'b0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % N_REQ;
            if (!grant_fnd && req_vld[cand]) begin
                grant_fnd = 1'b1;
                grant_idx = SRC_W'(cand);
            end
        end
    end

    assign grant_pay = req_dat[int'(grant_idx)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];

    assign load = run && (!init_req_stream_rsc_vld || init_req_stream_rsc_rdy)
                      && (free_cnt != '0) && grant_fnd;

    assign req_rdy = load ? (N_REQ'(1) << grant_idx) : '0;

`ifdef INIT_REQ_SCHED_DOUBLE_FREE_CHECK_EN
    logic [DEPTH-1:0] busy;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            busy <= '0;
        end else begin
            if (load)
                busy[free_list[head]] <= 1'b1;
            if (rel_ok)
                busy[rid_free_dat] <= 1'b0;
        end
    end

    assign rid_known = busy[rid_free_dat];
`else
    assign rid_known = 1'b1;
`endif

    // a free at full count, an unknown RID, or any free during FILL is dropped
    assign rel_ok  = run && rid_free_vld && (free_cnt != FULL_CNT) && rid_known;
    assign err_set = rid_free_vld && !rel_ok;

    always_ff @(posedge clk) begin
        if (!run)
            free_list[fill_cnt] <= fill_cnt;
        else if (rel_ok)
            free_list[tail] <= rid_free_dat;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state                   <= ST_FILL;
            fill_cnt                <= '0;
            head                    <= '0;
            tail                    <= '0;
            free_cnt                <= '0;
            rr_ptr                  <= '0;
            init_req_stream_rsc_vld <= 1'b0;
            init_req_stream_rsc_dat <= '0;
            init_req_src            <= '0;
            err                     <= 1'b0;
        end else begin
            if (err_set)
                err <= 1'b1;
            if (!run) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (fill_cnt == RID_WIDTH'(DEPTH-1)) begin
                    state    <= ST_RUN;
                    head     <= '0;
                    tail     <= '0;
                    free_cnt <= FULL_CNT;
                end
            end else begin
                if (load) begin
                    init_req_stream_rsc_vld <= 1'b1;
                    init_req_stream_rsc_dat <= {grant_pay, free_list[head]};
                    init_req_src            <= grant_idx;
                    head                    <= head + 1'b1;
                    rr_ptr                  <= (grant_idx == SRC_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
                end else if (init_req_stream_rsc_rdy) begin
                    init_req_stream_rsc_vld <= 1'b0;
                end
                if (rel_ok)
                    tail <= tail + 1'b1;
                case ({load, rel_ok})
                    2'b10:   free_cnt <= free_cnt - 1'b1;
                    2'b01:   free_cnt <= free_cnt + 1'b1;
                    default: free_cnt <= free_cnt;
                endcase
            end
        end
    end

    assign inflight = run ? (FULL_CNT - free_cnt) : '0;

endmodule

// File: tb/tb_init_req_sched.sv
// Bench for init_req_sched (N_REQ=4, RID_WIDTH=4): directed vector table, hand sequences and
// randomized traffic against a queue-based free-list reference model.
module tb_init_req_sched;
    localparam int N  = 4;
    localparam int RW = 4;
    localparam int PW = 32;
    localparam int D  = 16;
    localparam int SW = 2;
`ifdef INIT_REQ_SCHED_DOUBLE_FREE_CHECK_EN
    localparam bit DFC = 1'b1;
`else
    localparam bit DFC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic [N*PW-1:0]   req_dat = '0;
    logic [N-1:0]      req_vld = '0;
    logic [N-1:0]      req_rdy;
    logic [PW+RW-1:0]  o_dat;
    logic              o_vld;
    logic              o_rdy = 1'b0;
    logic [SW-1:0]     src;
    logic              free_vld = 1'b0;
    logic [RW-1:0]     free_dat = '0;
    logic [RW:0]       inflight;
    logic              err;

    init_req_sched #(.N_REQ(N), .RID_WIDTH(RW), .PAYLOAD_WIDTH(PW)) dut (
        .clk(clk), .arst(arst),
        .req_dat(req_dat), .req_vld(req_vld), .req_rdy(req_rdy),
        .init_req_stream_rsc_dat(o_dat), .init_req_stream_rsc_vld(o_vld),
        .init_req_stream_rsc_rdy(o_rdy), .init_req_src(src),
        .rid_free_vld(free_vld), .rid_free_dat(free_dat),
        .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int               fill_left;
    int               fq[$];
    bit               outst[D];
    int               rr;
    bit               m_vld;
    logic [PW+RW-1:0] m_dat;
    int               m_src;
    bit               m_err;

    typedef struct {
        logic [N-1:0]  rv;
        logic          ordy;
        logic          fv;
        logic [RW-1:0] fd;
        logic [N-1:0]  e_rdy;
        logic          e_vld;
        logic [RW-1:0] e_rid;
        logic [SW-1:0] e_src;
        int            e_infl;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick();
        if (fill_left != 0) return -1;
        if (m_vld && !o_rdy) return -1;
        if (fq.size() == 0) return -1;
        for (int k = 0; k < N; k++)
            if (req_vld[(rr + k) % N]) return (rr + k) % N;
        return -1;
    endfunction

    task automatic model_check();
        int g;
        logic [N-1:0] er;
        g  = pick();
        er = (g < 0) ? '0 : (N'(1) << g);
        check("req_rdy", req_rdy, er);
        check("out_vld", o_vld, m_vld);
        if (m_vld) begin
            check("out_dat", o_dat, m_dat);
            check("out_src", src, m_src);
        end
        check("inflight", inflight, (fill_left > 0) ? 0 : D - fq.size());
        check("err", err, m_err);
    endtask

    task automatic tick();
        int g;
        int rid;
        logic fv;
        logic [RW-1:0] fd;
        logic [N*PW-1:0] pd;
        logic ordy;
        bit rel_ok;
        #1;
        model_check();
        g = pick(); fv = free_vld; fd = free_dat; pd = req_dat; ordy = o_rdy;
        @(posedge clk);
        if (fill_left > 0) begin
            fill_left--;
            if (fv) m_err = 1'b1;
            if (fill_left == 0)
                for (int i = 0; i < D; i++) fq.push_back(i);
        end else begin
            rel_ok = 1'b0;
            if (fv) begin
                if (fq.size() == D)            m_err = 1'b1;
                else if (DFC && !outst[fd])    m_err = 1'b1;
                else                           rel_ok = 1'b1;
            end
            if (g >= 0) begin
                rid   = fq.pop_front();
                m_dat = {pd[g*PW +: PW], RW'(rid)};
                m_src = g;
                m_vld = 1'b1;
                rr    = (g + 1) % N;
                outst[rid] = 1'b1;
            end else if (ordy) begin
                m_vld = 1'b0;
            end
            if (rel_ok) begin
                fq.push_back(int'(fd));
                outst[fd] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // entered at a negedge; asynchronous assertion is checked before any clock edge
    task automatic do_reset();
        arst = 1'b1;
        free_vld = 1'b0;
        fill_left = D; fq.delete(); rr = 0;
        m_vld = 1'b0; m_dat = '0; m_src = 0; m_err = 1'b0;
        for (int i = 0; i < D; i++) outst[i] = 1'b0;
        #1;
        check("rst_vld", o_vld, 0);
        check("rst_dat", o_dat, 0);
        check("rst_src", src, 0);
        check("rst_inflight", inflight, 0);
        check("rst_err", err, 0);
        check("rst_rdy", req_rdy, 0);
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic fill_phase();
        for (int i = 0; i < D; i++) begin
            req_vld = N'($urandom);
            o_rdy   = 1'b1;
            tick();
        end
    endtask

    vec_t tbl[13];
    int   outl[$];

    initial begin
        tbl[0]  = '{4'hF, 1'b1, 1'b0, 4'd0, 4'b0001, 1'b0, 4'd0, 2'd0, 0};
        tbl[1]  = '{4'hF, 1'b1, 1'b0, 4'd0, 4'b0010, 1'b1, 4'd0, 2'd0, 1};
        tbl[2]  = '{4'hF, 1'b1, 1'b0, 4'd0, 4'b0100, 1'b1, 4'd1, 2'd1, 2};
        tbl[3]  = '{4'hF, 1'b1, 1'b0, 4'd0, 4'b1000, 1'b1, 4'd2, 2'd2, 3};
        tbl[4]  = '{4'hF, 1'b1, 1'b0, 4'd0, 4'b0001, 1'b1, 4'd3, 2'd3, 4};
        tbl[5]  = '{4'hF, 1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 4'd4, 2'd0, 5};
        tbl[6]  = '{4'hF, 1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 4'd4, 2'd0, 5};
        tbl[7]  = '{4'hF, 1'b0, 1'b0, 4'd0, 4'b0000, 1'b1, 4'd4, 2'd0, 5};
        tbl[8]  = '{4'hF, 1'b1, 1'b0, 4'd0, 4'b0010, 1'b1, 4'd4, 2'd0, 5};
        tbl[9]  = '{4'h0, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b1, 4'd5, 2'd1, 6};
        tbl[10] = '{4'h0, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b0, 4'd0, 2'd0, 6};
        tbl[11] = '{4'h4, 1'b1, 1'b1, 4'd2, 4'b0100, 1'b0, 4'd0, 2'd0, 6};
        tbl[12] = '{4'h0, 1'b1, 1'b0, 4'd0, 4'b0000, 1'b1, 4'd6, 2'd2, 6};

        @(negedge clk);
        do_reset();
        fill_phase();

        for (int i = 0; i < N; i++) req_dat[i*PW +: PW] = 32'hA000_0000 + i;
        for (int v = 0; v < 13; v++) begin
            req_vld = tbl[v].rv; o_rdy = tbl[v].ordy;
            free_vld = tbl[v].fv; free_dat = tbl[v].fd;
            #1;
            check("tbl_rdy", req_rdy, tbl[v].e_rdy);
            check("tbl_vld", o_vld, tbl[v].e_vld);
            if (tbl[v].e_vld) begin
                check("tbl_rid", o_dat[RW-1:0], tbl[v].e_rid);
                check("tbl_src", src, tbl[v].e_src);
            end
            check("tbl_inflight", inflight, tbl[v].e_infl);
            tick();
        end
        free_vld = 1'b0;

        // drain the free list completely
        req_vld = 4'hF; o_rdy = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        #1;
        check("exh_inflight", inflight, 16);
        check("exh_rdy", req_rdy, 0);
        free_vld = 1'b1; free_dat = 4'd5;
        #1;
        check("nobypass_rdy", req_rdy, 0);
        tick();
        free_vld = 1'b0;
        #1;
        check("refill_rdy", req_rdy, 4'b0010);
        tick();
        req_vld = '0;
        #1;
        check("refill_rid", o_dat[RW-1:0], 5);
        check("refill_src", src, 1);
        tick();

        // double free of RID 7
        free_vld = 1'b1; free_dat = 4'd7;
        tick();
        tick();
        free_vld = 1'b0;
        #1;
        check("dfree_err", err, DFC ? 1 : 0);
        tick();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) req_dat[i*PW +: PW] = $urandom;
            req_vld  = N'($urandom);
            o_rdy    = ($urandom_range(3) != 0);
            free_vld = ($urandom_range(9) < 4);
            outl.delete();
            for (int i = 0; i < D; i++) if (outst[i]) outl.push_back(i);
            if (outl.size() > 0 && $urandom_range(19) != 0)
                free_dat = RW'(outl[$urandom_range(outl.size()-1)]);
            else
                free_dat = RW'($urandom);
            tick();
        end
        free_vld = 1'b0;

        // reset with nine rays in flight and a beat pending
        do_reset();
        fill_phase();
        req_vld = 4'hF; o_rdy = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        #1;
        check("mid_inflight", inflight, 9);
        check("mid_vld", o_vld, 1);
        do_reset();
        fill_phase();

        // release with a full free list
        req_vld = '0;
        free_vld = 1'b1; free_dat = 4'd3;
        tick();
        free_vld = 1'b0;
        #1;
        check("ovf_err", err, 1);
        check("ovf_inflight", inflight, 0);
        tick();
        req_vld = 4'b0001;
        tick();
        req_vld = '0;
        #1;
        check("post_rst_vld", o_vld, 1);
        check("post_rst_rid", o_dat[RW-1:0], 0);
        check("sticky_err", err, 1);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
